// File: rtl/count_window_accumulator.sv
// count_window_accumulator
//   Sums up to WINDOW unsigned 4-bit counter samples into a SUM_W-bit total.
//   A window closes after WINDOW samples or early on flush. The result is
//   held on the output side until the downstream consumer accepts it.
//
// Parameters
//   WINDOW  samples per window (1..15)
//   SUM_W   width of the accumulated sum (4..8)
//
// Configuration macro
//   CWA_SATURATE_EN  defined   : the sum clamps at 2^SUM_W-1 on overflow
//                    undefined : the sum wraps modulo 2^SUM_W (default)
//   In both builds out_ovf is a sticky flag for the whole window.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   upstream sample valid
//   in_count   sample value (unsigned, 4 bits)
//   in_ready   a sample is accepted this cycle (low while a result is held)
//   flush      close the current window early
//   out_valid  window result available
//   out_ready  downstream accepts the result
//   out_sum    window sum (0 while out_valid is low)
//   out_n      number of samples in the window (0 while out_valid is low)
//   out_ovf    the sum overflowed during the window (0 while out_valid is low)
module count_window_accumulator #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_count,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [3:0]       out_n,
  output logic             out_ovf
);

  localparam logic [3:0] WIN = 4'(WINDOW);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [SUM_W-1:0] sum;
  logic [3:0]       n;
  logic             ovf;

  logic             accept;
  logic [SUM_W:0]   add;
  logic [SUM_W-1:0] sum_next;
  logic [3:0]       n_next;
  logic             ovf_next;
  logic             close;

  // The only non-accepting state is HOLD, so in_ready is a pure state decode.
  assign in_ready = (state != HOLD);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    accept   = in_valid && in_ready;
    add      = {1'b0, sum} + (SUM_W+1)'(in_count);
    sum_next = sum;
    n_next   = n;
    ovf_next = ovf;
    if (accept) begin
`ifdef CWA_SATURATE_EN
      sum_next = add[SUM_W] ? '1 : add[SUM_W-1:0];
`else
      sum_next = add[SUM_W-1:0];
`endif
      n_next   = n + 4'd1;
      ovf_next = ovf | add[SUM_W];
    end
    // A window closes when it fills, or on flush once it holds at least one
    // sample (either already in ACCUM or accepted together with the flush).
    close = (accept && (n_next == WIN)) ||
            (flush && ((state == ACCUM) || accept));
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sum       <= '0;
      n         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_n     <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (close) begin
            state     <= HOLD;
            sum       <= sum_next;
            n         <= n_next;
            ovf       <= ovf_next;
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_n     <= n_next;
            out_ovf   <= ovf_next;
          end else if (accept) begin
            state <= ACCUM;
            sum   <= sum_next;
            n     <= n_next;
            ovf   <= ovf_next;
          end
        end
        HOLD: begin
          // Flush and new samples are ignored; the result stays frozen
          // until the handshake.
          if (out_ready) begin
            state     <= IDLE;
            sum       <= '0;
            n         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_n     <= '0;
            out_ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
